inst_dispatch: RTL and testbench

Fetch-and-issue front end that feeds the NSLOT staggered multicycle pipe FSM slots.
- Owns the PC and reads instruction memory (1-cycle synchronous read).
- Hands one instruction at a time to slots in round-robin order, using each slot's fetch_req/ack handshake.
- On a taken branch or jump it redirects the PC and broadcasts flush/flush_pri so younger slots abort.

---
 rtl/inst_dispatch_pkg.sv | 20 ++
 rtl/inst_dispatch_rr_slot_ptr.sv | 30 +++
 rtl/inst_dispatch.sv | 129 ++++++++++++
 tb/tb_inst_dispatch.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_dispatch_pkg.sv
// Shared types and constants for the instruction fetch/dispatch front end.
package inst_dispatch_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          STAGE_W          = 3;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_HOLD,
        ST_GAP
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_dispatch_rr_slot_ptr.sv
// Round-robin slot pointer: advances on issue, reloads to the slot after
// the redirecting one.
module rr_slot_ptr #(
    parameter int NSLOT  = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              load,
    input  logic [SLOT_W-1:0] load_slot,
    output logic [SLOT_W-1:0] ptr
);

    // Explicit wrap so non-power-of-two slot counts still cycle correctly.
    function automatic logic [SLOT_W-1:0] succ(input logic [SLOT_W-1:0] s);
        return (s == SLOT_W'(NSLOT - 1)) ? '0 : s + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= succ(load_slot);
        end else if (advance) begin
            ptr <= succ(ptr);
        end
    end

endmodule

// File: rtl/inst_dispatch.sv
// Fetch-and-issue front end: owns the PC, reads imem and hands instructions
// round-robin to the pipe FSM slots, with redirect/flush on branches.
module inst_dispatch
    import inst_dispatch_pkg::*;
#(
    parameter int          NSLOT    = 4,
    parameter int          SLOT_W   = 2,
    parameter int          GAP      = 1,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NSLOT-1:0]         slot_fetch_req,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic [SLOT_W-1:0]        redirect_slot,
    input  logic [STAGE_W-1:0]       redirect_stage,
    output logic                     imem_rd,
    output logic [31:0]              imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic [NSLOT-1:0]         slot_en,
    output logic [NSLOT-1:0]         slot_ack,
    output logic [NSLOT*INSTR_W-1:0] slot_instr,
    output logic                     flush,
    output logic [STAGE_W-1:0]       flush_pri,
    output logic [31:0]              pc,
    output logic [SLOT_W-1:0]        next_slot
);

    localparam logic [31:0] GAP_LAST = (GAP > 0) ? 32'(GAP - 1) : 32'd0;

    state_t               state, state_nxt;
    logic [31:0]          gap_cnt;
    logic [INSTR_W-1:0]   hold_q;
    logic [INSTR_W-1:0]   issue_data;
    logic                 issue;
    logic                 do_flush;

    rr_slot_ptr #(
        .NSLOT  (NSLOT),
        .SLOT_W (SLOT_W)
    ) u_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (issue),
        .load      (redirect_valid),
        .load_slot (redirect_slot),
        .ptr       (next_slot)
    );

    assign imem_rd    = (state == ST_REQ);
    assign imem_addr  = pc;
    assign issue_data = (state == ST_HOLD) ? hold_q : imem_rdata;

    // Dropping start wins over everything; a redirect outside IDLE beats any issue.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        do_flush  = 1'b0;
        if (!start) begin
            state_nxt = ST_IDLE;
        end else if (state == ST_IDLE) begin
            state_nxt = ST_REQ;
        end else if (redirect_valid) begin
            state_nxt = ST_REQ;
            do_flush  = 1'b1;
        end else begin
            case (state)
                ST_REQ: state_nxt = ST_DATA;
                ST_DATA, ST_HOLD: begin
                    if (slot_fetch_req[next_slot]) begin
                        issue     = 1'b1;
                        state_nxt = (GAP == 0) ? ST_REQ : ST_GAP;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt = ST_REQ;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            gap_cnt    <= '0;
            hold_q     <= '0;
            slot_en    <= '0;
            slot_ack   <= '0;
            slot_instr <= '0;
            flush      <= 1'b0;
            flush_pri  <= '0;
        end else begin
            slot_en   <= {NSLOT{start}};
            flush     <= do_flush;
            flush_pri <= do_flush ? redirect_stage : '0;
            gap_cnt   <= (state == ST_GAP && state_nxt == ST_GAP) ? gap_cnt + 1'b1 : '0;
            if (state == ST_DATA && !issue) begin
                hold_q <= imem_rdata;
            end
            if (redirect_valid) begin
                pc <= word_align(redirect_pc);
            end else if (issue) begin
                pc <= pc + 32'd4;
            end
            for (int i = 0; i < NSLOT; i++) begin
                slot_ack[i] <= issue && (next_slot == SLOT_W'(i));
                if (issue && (next_slot == SLOT_W'(i))) begin
                    slot_instr[i*INSTR_W +: INSTR_W] <= issue_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_dispatch.sv
// Directed self-checking bench for inst_dispatch with a 1-cycle imem model.
module tb_inst_dispatch;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   slot_fetch_req = 4'hF;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_pc = 32'h0;
    logic [1:0]   redirect_slot = 2'd0;
    logic [2:0]   redirect_stage = 3'd0;
    logic         imem_rd;
    logic [31:0]  imem_addr;
    logic [31:0]  imem_rdata = 32'h0;
    logic [3:0]   slot_en;
    logic [3:0]   slot_ack;
    logic [127:0] slot_instr;
    logic         flush;
    logic [2:0]   flush_pri;
    logic [31:0]  pc;
    logic [1:0]   next_slot;

    int checks = 0;
    int errors = 0;

    inst_dispatch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .slot_fetch_req (slot_fetch_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_slot  (redirect_slot),
        .redirect_stage (redirect_stage),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .slot_en        (slot_en),
        .slot_ack       (slot_ack),
        .slot_instr     (slot_instr),
        .flush          (flush),
        .flush_pri      (flush_pri),
        .pc             (pc),
        .next_slot      (next_slot)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: two real opcodes, a recognisable pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h2008_0005;
            32'h4: return 32'h2009_0003;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem_word(imem_addr);
    end

    function automatic logic [31:0] instr_of(input int i);
        return slot_instr[i*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        slot_fetch_req = 4'hF;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        redirect_slot = 2'd0;
        redirect_stage = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int max_cycles, output logic [3:0] ack, output int cycles);
        ack = 4'h0;
        cycles = max_cycles;
        for (int i = 1; i <= max_cycles; i++) begin
            step();
            if (slot_ack != 4'h0) begin
                ack = slot_ack;
                cycles = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 32'h0 || next_slot !== 2'd0 || slot_ack !== 4'h0 || flush !== 1'b0 ||
            flush_pri !== 3'd0 || slot_en !== 4'h0 || slot_instr !== 128'h0 || imem_rd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: pc=%h ns=%0d ack=%b flush=%b pri=%0d en=%b rd=%b, required all zero",
                     pc, next_slot, slot_ack, flush, flush_pri, slot_en, imem_rd);
        end
    endtask

    task automatic test_basic_issue();
        logic [3:0] ack;
        int cyc;
        do_reset();
        start = 1'b1;
        step();
        checks++;
        if (slot_en !== 4'hF || imem_rd !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL first_req: en=%b rd=%b addr=%h, required en=1111 rd=1 addr=0", slot_en, imem_rd, imem_addr);
        end
        wait_ack(10, ack, cyc);
        checks++;
        if (ack !== 4'b0001 || cyc !== 2 || instr_of(0) !== 32'h2008_0005 || pc !== 32'h4 || next_slot !== 2'd1) begin
            errors++;
            $display("[TB] FAIL first_issue: ack=%b cyc=%0d instr0=%h pc=%h ns=%0d, required 0001 2 20080005 4 1",
                     ack, cyc, instr_of(0), pc, next_slot);
        end
        step();
        checks++;
        if (slot_ack !== 4'h0) begin
            errors++;
            $display("[TB] FAIL ack_single_cycle: ack=%b, required 0000", slot_ack);
        end
        wait_ack(10, ack, cyc);
        checks++;
        if (ack !== 4'b0010 || (cyc + 1) !== 3 || instr_of(1) !== 32'h2009_0003 ||
            instr_of(0) !== 32'h2008_0005 || pc !== 32'h8) begin
            errors++;
            $display("[TB] FAIL second_issue: ack=%b spacing=%0d instr1=%h instr0=%h pc=%h, required 0010 3 20090003 20080005 8",
                     ack, cyc + 1, instr_of(1), instr_of(0), pc);
        end
    endtask

    task automatic test_hold();
        logic [3:0] ack;
        int cyc;
        int bad;
        do_reset();
        start = 1'b1;
        wait_ack(10, ack, cyc);
        wait_ack(10, ack, cyc);
        slot_fetch_req = 4'b1011;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (slot_ack !== 4'h0 || pc !== 32'h8) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL hold_no_ack: %0d cycles with ack or pc change, required 0", bad);
        end
        slot_fetch_req = 4'hF;
        step();
        checks++;
        if (slot_ack !== 4'b0100 || instr_of(2) !== 32'h5A5A_0008 || pc !== 32'hC || next_slot !== 2'd3) begin
            errors++;
            $display("[TB] FAIL hold_release: ack=%b instr2=%h pc=%h ns=%0d, required 0100 5a5a0008 c 3",
                     slot_ack, instr_of(2), pc, next_slot);
        end
    endtask

    task automatic test_redirect();
        logic [3:0] ack;
        int cyc;
        do_reset();
        start = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        redirect_slot = 2'd1;
        redirect_stage = 3'd2;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (slot_ack !== 4'h0 || flush !== 1'b1 || flush_pri !== 3'd2 || pc !== 32'h40 ||
            next_slot !== 2'd2 || slot_instr !== 128'h0) begin
            errors++;
            $display("[TB] FAIL redirect_cycle: ack=%b flush=%b pri=%0d pc=%h ns=%0d, required 0000 1 2 40 2",
                     slot_ack, flush, flush_pri, pc, next_slot);
        end
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("[TB] FAIL redirect_fetch: rd=%b addr=%h, required 1 40", imem_rd, imem_addr);
        end
        step();
        checks++;
        if (flush !== 1'b0 || flush_pri !== 3'd0) begin
            errors++;
            $display("[TB] FAIL flush_pulse: flush=%b pri=%0d, required 0 0", flush, flush_pri);
        end
        wait_ack(10, ack, cyc);
        checks++;
        if (ack !== 4'b0100 || instr_of(2) !== 32'h5A5A_0040 || pc !== 32'h44) begin
            errors++;
            $display("[TB] FAIL redirect_issue: ack=%b instr2=%h pc=%h, required 0100 5a5a0040 44", ack, instr_of(2), pc);
        end
    endtask

    task automatic test_idle_redirect();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        redirect_slot = 2'd0;
        redirect_stage = 3'd5;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (pc !== 32'h40 || next_slot !== 2'd1 || flush !== 1'b0 || flush_pri !== 3'd0) begin
            errors++;
            $display("[TB] FAIL idle_redirect: pc=%h ns=%0d flush=%b pri=%0d, required 40 1 0 0",
                     pc, next_slot, flush, flush_pri);
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  ack;
        int          cyc;
        logic [3:0]  exp_ack [5];
        logic [31:0] exp_addr [5];
        exp_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_addr = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        redirect_slot = 2'd3;
        redirect_stage = 3'd1;
        step();
        redirect_valid = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(10, ack, cyc);
            checks++;
            if (ack !== exp_ack[k] || instr_of(k % 4) !== mem_word(exp_addr[k]) ||
                pc !== exp_addr[k] + 32'd4) begin
                errors++;
                $display("[TB] FAIL wrap_issue%0d: ack=%b instr=%h pc=%h, required %b %h %h",
                         k, ack, instr_of(k % 4), pc, exp_ack[k], mem_word(exp_addr[k]), exp_addr[k] + 32'd4);
            end
        end
    endtask

    task automatic test_start_drop();
        logic [3:0] ack;
        int cyc;
        int bad;
        do_reset();
        start = 1'b1;
        wait_ack(10, ack, cyc);
        start = 1'b0;
        step();
        checks++;
        if (slot_en !== 4'h0 || slot_ack !== 4'h0) begin
            errors++;
            $display("[TB] FAIL start_drop: en=%b ack=%b, required 0000 0000", slot_en, slot_ack);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (slot_ack !== 4'h0 || imem_rd !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || pc !== 32'h4 || next_slot !== 2'd1) begin
            errors++;
            $display("[TB] FAIL idle_retain: bad=%0d pc=%h ns=%0d, required 0 4 1", bad, pc, next_slot);
        end
        start = 1'b1;
        step();
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 32'h4 || slot_en !== 4'hF) begin
            errors++;
            $display("[TB] FAIL resume_fetch: rd=%b addr=%h en=%b, required 1 4 1111", imem_rd, imem_addr, slot_en);
        end
        wait_ack(10, ack, cyc);
        checks++;
        if (ack !== 4'b0010 || instr_of(1) !== 32'h2009_0003) begin
            errors++;
            $display("[TB] FAIL resume_issue: ack=%b instr1=%h, required 0010 20090003", ack, instr_of(1));
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ack;
        int cyc;
        do_reset();
        start = 1'b1;
        wait_ack(10, ack, cyc);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (slot_ack !== 4'h0 || pc !== 32'h0 || slot_instr !== 128'h0 || next_slot !== 2'd0 || slot_en !== 4'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: ack=%b pc=%h instr0=%h ns=%0d en=%b, required all zero",
                     slot_ack, pc, instr_of(0), next_slot, slot_en);
        end
        step();
        checks++;
        if (slot_ack !== 4'h0 || imem_rd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: ack=%b rd=%b, required 0000 0", slot_ack, imem_rd);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_hold();
        test_redirect();
        test_idle_redirect();
        test_wrap();
        test_start_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
